// File: rtl/cpu_alu_seq.sv
// Sequential execute-stage ALU: RV base integer ops plus iterative M-extension.
// Latency: base ops 1 cycle, M ops WIDTH+1 cycles, accept edge to o_valid. One op in flight.
// Backpressure: the result is held in DONE until i_ready; no request is accepted until IDLE.
//
// Optional divider: define CPU_ALU_DIV_EN to build DIV/DIVU/REM/REMU. Without it those
// codes behave as invalid ops and return 0 after 1 cycle.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready    request handshake; o_ready is high only in IDLE
//   i_op, i_m            opcode; i_m selects the M-extension group via i_op[2:0]
//   i_a, i_b             operands rs1 / rs2, captured at accept
//   o_valid / i_ready    result handshake; o_y is stable while o_valid is high
//   o_y                  result
module cpu_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic             i_m,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef CPU_ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    // Iteration registers. The multiplier and divider share them:
    //   MUL: acc_hi = partial product high half, acc_lo = multiplier / product low half,
    //        opnd = multiplicand magnitude.
    //   DIV: acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in,
    //        opnd = divisor magnitude.
    logic [SW-1:0]    cnt;
    logic [1:0]       sel_lo;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
`ifdef CPU_ALU_DIV_EN
    logic             neg_r;
`endif

    // ------------------------------------------------------------------
    // Base (single-cycle) result, computed straight from the inputs
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] base_y;
    logic [SW-1:0]    shamt;

    always_comb begin
        base_y = '0;
        shamt  = i_b[SW-1:0];
        case (i_op)
            4'b0000: base_y = i_a + i_b;
            4'b1000: base_y = i_a - i_b;
            4'b0001: base_y = i_a << shamt;
            4'b0101: base_y = i_a >> shamt;
            4'b1101: base_y = $unsigned($signed(i_a) >>> shamt);
            4'b0010: base_y = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            4'b0011: base_y = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            4'b0100: base_y = i_a ^ i_b;
            4'b0110: base_y = i_a | i_b;
            4'b0111: base_y = i_a & i_b;
            default: base_y = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning: which operands are signed for this M op, and
    // their magnitudes. The iterative engines only ever see magnitudes.
    // ------------------------------------------------------------------
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (!i_op[2]) begin
            // MUL is sign-agnostic in its low half; MULH both signed; MULHSU only A.
            a_sgn = (i_op[1:0] == 2'b01) || (i_op[1:0] == 2'b10);
            b_sgn = (i_op[1:0] == 2'b01);
        end else begin
            // DIV / REM signed, DIVU / REMU unsigned.
            a_sgn = !i_op[0];
            b_sgn = !i_op[0];
        end
        a_neg = a_sgn && i_a[WIDTH-1];
        b_neg = b_sgn && i_b[WIDTH-1];
        a_mag = a_neg ? (~i_a + WIDTH'(1)) : i_a;
        b_mag = b_neg ? (~i_b + WIDTH'(1)) : i_b;
    end

    // ------------------------------------------------------------------
    // Multiplier step (shift-add, LSB first) and final sign fix
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mul_y;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
        prod     = {mul_hi_n, mul_lo_n};
        // Sign applied to the full double-width product so the high half is exact.
        prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
        mul_y    = (sel_lo == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end

`ifdef CPU_ALU_DIV_EN
    // ------------------------------------------------------------------
    // Divider step (restoring, MSB first) and final sign fix.
    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder ends up equal to the dividend magnitude with no special case;
    // neg_q is forced low at accept for that case so DIV keeps all ones.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] div_y;

    always_comb begin
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (!div_diff[WIDTH]) begin
            rem_n = div_diff[WIDTH-1:0];
            quo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = div_sh[WIDTH-1:0];
            quo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end
        quo_fix = neg_q ? (~quo_n + WIDTH'(1)) : quo_n;
        rem_fix = neg_r ? (~rem_n + WIDTH'(1)) : rem_n;
        div_y   = sel_lo[1] ? rem_fix : quo_fix;
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                accept  = i_valid;
                if (i_valid) begin
                    if (i_m && !i_op[2]) begin
                        state_nxt = S_MUL;
                    end
`ifdef CPU_ALU_DIV_EN
                    else if (i_m) begin
                        state_nxt = S_DIV;
                    end
`endif
                    else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
`ifdef CPU_ALU_DIV_EN
            S_DIV: begin
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            sel_lo <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
`ifdef CPU_ALU_DIV_EN
            neg_r  <= 1'b0;
`endif
            o_y    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            sel_lo <= i_op[1:0];
            if (!i_m) begin
                o_y <= base_y;
            end else if (!i_op[2]) begin
                acc_hi <= '0;
                acc_lo <= b_mag;
                opnd   <= a_mag;
                neg_q  <= a_neg ^ b_neg;
            end else begin
`ifdef CPU_ALU_DIV_EN
                acc_hi <= '0;
                acc_lo <= a_mag;
                opnd   <= b_mag;
                neg_q  <= (a_neg ^ b_neg) && (i_b != '0);
                neg_r  <= a_neg;
`else
                o_y    <= '0;
`endif
            end
        end else if (state == S_MUL) begin
            cnt    <= cnt + SW'(1);
            acc_hi <= mul_hi_n;
            acc_lo <= mul_lo_n;
            if (cnt == LAST) begin
                o_y <= mul_y;
            end
        end
`ifdef CPU_ALU_DIV_EN
        else if (state == S_DIV) begin
            cnt    <= cnt + SW'(1);
            acc_hi <= rem_n;
            acc_lo <= quo_n;
            if (cnt == LAST) begin
                o_y <= div_y;
            end
        end
`endif
    end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Self-checking bench for cpu_alu_seq (WIDTH=32): directed corner cases followed by
// randomized ops, all compared against an arithmetic reference model.
// Checks result value, accept-to-valid latency, hold under backpressure and release.
module tb_cpu_alu_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_op;
    logic        i_m;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_y;

    int total = 0;
    int bad   = 0;

    cpu_alu_seq #(.WIDTH(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_m     (i_m),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_y     (o_y)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the specified semantics.
    task automatic ref_model(input logic m, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] y, output int lat);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] pp;
        int          sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        sh  = int'(b % 32);
        y   = 32'h0;
        lat = 1;
        if (!m) begin
            case (op)
                4'b0000: y = a + b;
                4'b1000: y = a - b;
                4'b0001: y = a << sh;
                4'b0101: y = a >> sh;
                4'b1101: y = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                4'b0010: y = (sa < sb) ? 32'd1 : 32'd0;
                4'b0011: y = (ub < longint'({32'h0, a})) ? 32'd0 : ((a == b) ? 32'd0 : 32'd1);
                4'b0100: y = a ^ b;
                4'b0110: y = a | b;
                4'b0111: y = a & b;
                default: y = 32'h0;
            endcase
        end else if (!op[2]) begin
            lat = 33;
            case (op[1:0])
                2'b00: begin pp = {32'h0, a} * {32'h0, b}; y = pp[31:0];  end
                2'b01: begin pp = sa * sb;                 y = pp[63:32]; end
                2'b10: begin pp = sa * ub;                 y = pp[63:32]; end
                default: begin pp = {32'h0, a} * {32'h0, b}; y = pp[63:32]; end
            endcase
        end else begin
`ifdef CPU_ALU_DIV_EN
            lat = 33;
            case (op[1:0])
                2'b00: begin pp = (b == 0) ? 64'hFFFF_FFFF : sa / sb; y = pp[31:0]; end
                2'b01: y = (b == 0) ? 32'hFFFF_FFFF : a / b;
                2'b10: begin pp = (b == 0) ? sa : sa % sb; y = pp[31:0]; end
                default: y = (b == 0) ? a : a % b;
            endcase
`else
            y = 32'h0;
`endif
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: pick = 32'h0;
            1: pick = 32'h1;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'h8000_0000;
            4: pick = 32'h7FFF_FFFF;
            5: pick = 32'($urandom % 16);
            default: pick = $urandom;
        endcase
    endfunction

    task automatic pulse_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // One full transaction: issue, measure latency, check result, optional hold, release.
    task automatic run_op(input string tag, input logic m, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] ey;
        int          elat;
        int          n;
        logic        got;
        ref_model(m, op, a, b, ey, elat);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_m     = m;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        // Scramble inputs: the op must already be captured.
        i_valid = 1'b0;
        i_m     = 1'($urandom);
        i_op    = 4'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
        n   = 1;
        got = 1'b0;
        while (n <= 100) begin
            @(negedge i_clk);
            if (o_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge i_clk);
            n++;
        end
        if (!got) begin
            check({tag, " timeout"}, 64'(got), 64'd1);
            pulse_reset();
            return;
        end
        check({tag, " latency"}, 64'(n), 64'(elat));
        check({tag, " y"}, 64'(o_y), 64'(ey));
        if (hold > 0) begin
            repeat (hold) @(negedge i_clk);
            check({tag, " hold y"}, 64'(o_y), 64'(ey));
            check({tag, " hold ready"}, 64'(o_ready), 64'd0);
            check({tag, " hold valid"}, 64'(o_valid), 64'd1);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check({tag, " release valid"}, 64'(o_valid), 64'd0);
        check({tag, " release ready"}, 64'(o_ready), 64'd1);
        i_ready = 1'b0;
    endtask

    initial begin
        logic        rm;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_m     = 1'b0;
        i_op    = 4'h0;
        i_a     = 32'h0;
        i_b     = 32'h0;
        i_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset valid", 64'(o_valid), 64'd0);
        check("reset y", 64'(o_y), 64'd0);
        check("reset ready", 64'(o_ready), 64'd1);

        // Directed corner cases
        run_op("add ovf", 1'b0, 4'b0000, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("sra", 1'b0, 4'b1101, 32'h8000_0000, 32'h21, 0);
        run_op("sltu", 1'b0, 4'b0011, 32'h1, 32'hFFFF_FFFF, 0);
        run_op("slt", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("bad op", 1'b0, 4'b1111, 32'h1234, 32'h5678, 0);
        run_op("mulh", 1'b1, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu", 1'b1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu", 1'b1, 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul", 1'b1, 4'b0000, 32'h0001_2345, 32'hFFFF_FFFD, 0);
        run_op("div0", 1'b1, 4'b0100, 32'h7, 32'h0, 0);
        run_op("rem0", 1'b1, 4'b0110, 32'h7, 32'h0, 0);
        run_op("div0 neg", 1'b1, 4'b0100, 32'hFFFF_FFF9, 32'h0, 0);
        run_op("div ovf", 1'b1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem ovf", 1'b1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem neg", 1'b1, 4'b0110, 32'hFFFF_FFF9, 32'h2, 0);
        run_op("backpressure", 1'b0, 4'b0000, 32'h10, 32'h20, 5);

        // Request arriving while the result is being consumed is taken a cycle later.
        @(negedge i_clk);
        i_valid = 1'b1; i_m = 1'b0; i_op = 4'b0000; i_a = 32'd10; i_b = 32'd20;
        @(posedge i_clk);
        #1;
        i_a = 32'd4; i_b = 32'd5;
        @(negedge i_clk);
        check("overlap first y", 64'(o_y), 64'd30);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("overlap no accept valid", 64'(o_valid), 64'd0);
        check("overlap no accept ready", 64'(o_ready), 64'd1);
        i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("overlap second valid", 64'(o_valid), 64'd1);
        check("overlap second y", 64'(o_y), 64'd9);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;

        // Reset in the middle of a multiply
        @(negedge i_clk);
        i_valid = 1'b1; i_m = 1'b1; i_op = 4'b0000; i_a = 32'd1000; i_b = 32'd3;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("midrst valid", 64'(o_valid), 64'd0);
        check("midrst y", 64'(o_y), 64'd0);
        check("midrst ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        run_op("add after rst", 1'b0, 4'b0000, 32'd2, 32'd3, 0);

        // Randomized ops
        for (int i = 0; i < 150; i++) begin
            rm  = 1'($urandom);
            rop = 4'($urandom);
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rnd%0d m=%0d op=%0h a=%0h b=%0h", i, rm, rop, ra, rb),
                   rm, rop, ra, rb, int'($urandom % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
